// File: rtl/clint_bus_bridge.sv
// Single-outstanding bridge from the core MMIO port to the CLINT request interface.
// Optional ISSUE timeout is built only when CLINT_BRIDGE_TIMEOUT_EN is defined.
module clint_bus_bridge #(
   parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req_valid,
   input  logic [31:0] cpu_req_addr,
   input  logic [63:0] cpu_req_wdata,
   input  logic        cpu_req_we,
   input  logic [2:0]  cpu_req_size,
   output logic        cpu_req_ready,
   output logic        cpu_rsp_valid,
   output logic [63:0] cpu_rsp_rdata,
   output logic        cpu_rsp_error,
   output logic        clint_req_valid,
   output logic [15:0] clint_req_addr,
   output logic [63:0] clint_req_wdata,
   output logic        clint_req_we,
   output logic [2:0]  clint_req_size,
   input  logic        clint_req_ready,
   input  logic [63:0] clint_req_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || (BASE_ADDR[15:0] != 16'h0000)) begin : g_bad_param
      $error("clint_bus_bridge: illegal BASE_ADDR or TIMEOUT_CYCLES");
   end

   function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] lsb);
      case (size)
         3'd0:    is_aligned = 1'b1;
         3'd1:    is_aligned = (lsb[0] == 1'b0);
         3'd2:    is_aligned = (lsb[1:0] == 2'b00);
         3'd3:    is_aligned = (lsb == 3'b000);
         default: is_aligned = 1'b0;
      endcase
   endfunction

   logic [1:0]  state_r;
   logic [15:0] addr_r;
   logic [63:0] wdata_r;
   logic        we_r;
   logic [2:0]  size_r;
   logic [63:0] rdata_r;
   logic        error_r;
   logic        hit_s;
   logic        aligned_s;
   logic        expire_s;

   assign hit_s     = (cpu_req_addr[31:16] == BASE_ADDR[31:16]);
   assign aligned_s = is_aligned(cpu_req_size, cpu_req_addr[2:0]);

`ifdef CLINT_BRIDGE_TIMEOUT_EN
   logic [15:0] cnt_r;

   assign expire_s = (cnt_r == 16'(TIMEOUT_CYCLES - 1));

   // Count ISSUE cycles without a CLINT completion; idle clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= 16'd0;
      end else if (state_r == ST_IDLE) begin
         cnt_r <= 16'd0;
      end else if ((state_r == ST_ISSUE) && !clint_req_ready) begin
         cnt_r <= cnt_r + 16'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end
`else
   assign expire_s = 1'b0;
`endif

   // Transaction FSM with request latch and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         addr_r  <= 16'h0000;
         wdata_r <= 64'h0;
         we_r    <= 1'b0;
         size_r  <= 3'd0;
         rdata_r <= 64'h0;
         error_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cpu_req_valid) begin
                  addr_r  <= cpu_req_addr[15:0];
                  wdata_r <= cpu_req_wdata;
                  we_r    <= cpu_req_we;
                  size_r  <= cpu_req_size;
                  if (hit_s && aligned_s) begin
                     state_r <= ST_ISSUE;
                  end else begin
                     rdata_r <= 64'h0;
                     error_r <= 1'b1;
                     state_r <= ST_RESP;
                  end
               end
            end
            ST_ISSUE: begin
               // Completion wins over a timeout expiring in the same cycle.
               if (clint_req_ready) begin
                  rdata_r <= we_r ? 64'h0 : clint_req_rdata;
                  error_r <= 1'b0;
                  state_r <= ST_RESP;
               end else if (expire_s) begin
                  rdata_r <= 64'h0;
                  error_r <= 1'b1;
                  state_r <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_req_ready   = (state_r == ST_IDLE);
   assign cpu_rsp_valid   = (state_r == ST_RESP);
   assign cpu_rsp_rdata   = rdata_r;
   assign cpu_rsp_error   = error_r;
   assign clint_req_valid = (state_r == ST_ISSUE);
   assign clint_req_addr  = addr_r;
   assign clint_req_wdata = wdata_r;
   assign clint_req_we    = we_r;
   assign clint_req_size  = size_r;

endmodule
